pc_sequencer: RTL and testbench

Program-counter and fetch-sequencing block for the single-cycle 8-bit core. It drives the instruction-memory address and resolves taken branches from the ALU `jump` flag, using either relative or absolute (LUT) targets. It also enforces a one-cycle fetch bubble after each taken branch, since the instruction memory output is registered. It handles start/halt run control and counts executed cycles for program benchmarking.

---
 rtl/pc_sequencer_pkg.sv | 27 ++
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer_pc_next_calc.sv | 22 ++
 rtl/pc_sequencer.sv | 86 ++++++++
 tb/tb_pc_sequencer.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_sequencer_pkg;

   localparam int PC_W_DEF   = 10;  // instruction-address width
   localparam int DATA_W_DEF = 8;   // datapath / branch-offset width
   localparam int CNT_W_DEF  = 16;  // cycle-counter width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } pc_state_e;

   // ASCII name of a state, for viewing as a string in waveforms
   // the same way the ALU op mnemonics are shown.
   function automatic logic [39:0] state_mnemonic(input pc_state_e s);
      case (s)
         IDLE:    state_mnemonic = "IDLE ";
         RUN:     state_mnemonic = "RUN  ";
         FLUSH:   state_mnemonic = "FLUSH";
         DONE:    state_mnemonic = "DONE ";
         default: state_mnemonic = "?????";
      endcase
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Run-control / branch / fetch-address bundle between the core and the sequencer.
interface pc_sequencer_if #(
   parameter int PW = 10,
   parameter int W  = 8,
   parameter int CW = 16
);
   logic          Start;
   logic [PW-1:0] StartAddr;
   logic          Stall;
   logic          Halt;
   logic          Jump;
   logic          BranchRel;
   logic [W-1:0]  Offset;
   logic [PW-1:0] Target;
   logic [PW-1:0] PC;
   logic          InstValid;
   logic          Running;
   logic          Done;
   logic [CW-1:0] CycleCount;

   // core / decode side
   modport master (
      output Start, StartAddr, Stall, Halt, Jump, BranchRel, Offset, Target,
      input  PC, InstValid, Running, Done, CycleCount
   );

   // sequencer side
   modport slave (
      input  Start, StartAddr, Stall, Halt, Jump, BranchRel, Offset, Target,
      output PC, InstValid, Running, Done, CycleCount
   );
endinterface

// File: rtl/pc_sequencer_pc_next_calc.sv
// Next-PC arithmetic: sequential increment and branch target.
// All address widths and the offset sign extension live here.
module pc_next_calc #(
   parameter int PW = 10,
   parameter int W  = 8
) (
   input  logic [PW-1:0] PC,
   input  logic          BranchRel,
   input  logic [W-1:0]  Offset,
   input  logic [PW-1:0] Target,
   output logic [PW-1:0] PcInc,
   output logic [PW-1:0] BrTarget
);
   logic [PW-1:0] off_ext;

   // Sign-extend the offset to address width; all sums wrap modulo 2^PW.
   always_comb begin
      off_ext  = PW'($signed(Offset));
      PcInc    = PC + PW'(1);
      BrTarget = BranchRel ? (PC + off_ext) : Target;
   end
endmodule

// File: rtl/pc_sequencer.sv
// PC register, run-control FSM and saturating cycle counter.
// Outputs depend only on registered state.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int PW = PC_W_DEF,
   parameter int W  = DATA_W_DEF,
   parameter int CW = CNT_W_DEF
) (
   input  logic           Clk,
   input  logic           Reset,
   pc_sequencer_if.slave  bus
);
   pc_state_e     state_q, state_d;
   logic [PW-1:0] pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pc_inc, br_target;
   logic [CW-1:0] cnt_inc;

   pc_next_calc #(.PW(PW), .W(W)) u_next (
      .PC        (pc_q),
      .BranchRel (bus.BranchRel),
      .Offset    (bus.Offset),
      .Target    (bus.Target),
      .PcInc     (pc_inc),
      .BrTarget  (br_target)
   );

   // Counter sticks at all-ones instead of wrapping.
   assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

   // Next state: a stall freezes everything; halt beats jump in RUN;
   // FLUSH is the bubble after a taken branch and ignores halt/jump.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      if (!bus.Stall) begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.Start) begin
                  pc_d    = bus.StartAddr;
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               cnt_d = cnt_inc;
               if (bus.Halt) begin
                  state_d = DONE;
               end else if (bus.Jump) begin
                  pc_d    = br_target;
                  state_d = FLUSH;
               end else begin
                  pc_d = pc_inc;
               end
            end
            FLUSH: begin
               cnt_d   = cnt_inc;
               pc_d    = pc_inc;
               state_d = RUN;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, PC and counter registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.PC         = pc_q;
   assign bus.InstValid  = (state_q == RUN);
   assign bus.Running    = (state_q == RUN) || (state_q == FLUSH);
   assign bus.Done       = (state_q == DONE);
   assign bus.CycleCount = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer plus a CW=4 saturation instance.
module tb_pc_sequencer;
   logic Clk;
   logic Reset;

   pc_sequencer_if #(.PW(10), .W(8), .CW(16)) bus ();
   pc_sequencer_if #(.PW(10), .W(8), .CW(4))  sbus ();

   pc_sequencer #(.PW(10), .W(8), .CW(16)) dut  (.Clk(Clk), .Reset(Reset), .bus(bus));
   pc_sequencer #(.PW(10), .W(8), .CW(4))  sdut (.Clk(Clk), .Reset(Reset), .bus(sbus));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       start;
      logic [9:0] saddr;
      logic       stall, halt, jump, rel;
      logic [7:0] off;
      logic [9:0] tgt;
      logic [9:0] pc;
      logic       iv, run, done;
      logic [15:0] cnt;
   } vec_t;

   vec_t tv [34];

   function automatic vec_t mk(input logic st, input logic [9:0] sa, input logic sl,
                               input logic h, input logic j, input logic r,
                               input logic [7:0] o, input logic [9:0] t,
                               input logic [9:0] pc, input logic iv, input logic run,
                               input logic dn, input logic [15:0] cnt);
      vec_t v;
      v.start = st; v.saddr = sa; v.stall = sl; v.halt = h; v.jump = j; v.rel = r;
      v.off = o; v.tgt = t; v.pc = pc; v.iv = iv; v.run = run; v.done = dn; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_in;
      bus.Start = 0; bus.StartAddr = '0; bus.Stall = 0; bus.Halt = 0;
      bus.Jump = 0; bus.BranchRel = 0; bus.Offset = '0; bus.Target = '0;
   endtask

   task automatic chk_main(input string tag, input int pc, input int iv,
                           input int run, input int dn, input int cnt);
      chk({tag, ".PC"},         int'(bus.PC),         pc);
      chk({tag, ".InstValid"},  int'(bus.InstValid),  iv);
      chk({tag, ".Running"},    int'(bus.Running),    run);
      chk({tag, ".Done"},       int'(bus.Done),       dn);
      chk({tag, ".CycleCount"}, int'(bus.CycleCount), cnt);
   endtask

   initial begin
      // row: start saddr stall halt jump rel off tgt | pc iv run done cnt
      tv[0]  = mk(1, 10'h005, 0,0,0,0, 8'h00, 10'h000,  10'h005,1,1,0, 0);  // start
      tv[1]  = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h006,1,1,0, 1);
      tv[2]  = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h007,1,1,0, 2);
      tv[3]  = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h008,1,1,0, 3);
      tv[4]  = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h009,1,1,0, 4);
      tv[5]  = mk(1, 10'h010, 0,0,0,0, 8'h00, 10'h000,  10'h00A,1,1,0, 5);  // start in RUN ignored
      tv[6]  = mk(0, 10'h000, 0,0,1,0, 8'h00, 10'h00F,  10'h00F,0,1,0, 6);  // abs jump
      tv[7]  = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h010,1,1,0, 7);
      tv[8]  = mk(0, 10'h000, 0,0,1,1, 8'hFC, 10'h000,  10'h00C,0,1,0, 8);  // rel -4
      tv[9]  = mk(0, 10'h000, 0,0,1,0, 8'h00, 10'h100,  10'h00D,1,1,0, 9);  // jump in FLUSH ignored
      tv[10] = mk(0, 10'h000, 0,0,1,0, 8'h00, 10'h200,  10'h200,0,1,0, 10); // abs 0x200
      tv[11] = mk(0, 10'h000, 0,1,1,0, 8'h00, 10'h100,  10'h201,1,1,0, 11); // halt+jump in FLUSH ignored
      tv[12] = mk(0, 10'h000, 0,0,1,0, 8'h00, 10'h3FD,  10'h3FD,0,1,0, 12);
      tv[13] = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h3FE,1,1,0, 13);
      tv[14] = mk(0, 10'h000, 0,0,1,1, 8'h05, 10'h000,  10'h003,0,1,0, 14); // rel wrap
      tv[15] = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h004,1,1,0, 15);
      tv[16] = mk(0, 10'h000, 0,0,1,0, 8'h00, 10'h3FE,  10'h3FE,0,1,0, 16);
      tv[17] = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h3FF,1,1,0, 17);
      tv[18] = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h000,1,1,0, 18); // sequential wrap
      tv[19] = mk(0, 10'h000, 0,0,1,1, 8'h1F, 10'h000,  10'h01F,0,1,0, 19);
      tv[20] = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h020,1,1,0, 20);
      tv[21] = mk(0, 10'h000, 0,1,1,0, 8'h00, 10'h100,  10'h020,0,0,1, 21); // halt beats jump
      tv[22] = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h020,0,0,1, 21);
      tv[23] = mk(0, 10'h000, 0,0,1,0, 8'h00, 10'h100,  10'h020,0,0,1, 21); // DONE holds
      tv[24] = mk(1, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h000,1,1,0, 0);  // restart
      tv[25] = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h001,1,1,0, 1);
      tv[26] = mk(0, 10'h000, 0,0,1,0, 8'h00, 10'h02F,  10'h02F,0,1,0, 2);
      tv[27] = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h030,1,1,0, 3);
      tv[28] = mk(0, 10'h000, 1,0,1,0, 8'h00, 10'h123,  10'h030,1,1,0, 3);  // stalled branch
      tv[29] = mk(0, 10'h000, 1,0,1,0, 8'h00, 10'h123,  10'h030,1,1,0, 3);
      tv[30] = mk(0, 10'h000, 1,0,1,0, 8'h00, 10'h123,  10'h030,1,1,0, 3);
      tv[31] = mk(0, 10'h000, 0,0,1,0, 8'h00, 10'h123,  10'h123,0,1,0, 4);  // taken after stall
      tv[32] = mk(0, 10'h000, 1,0,0,0, 8'h00, 10'h000,  10'h123,0,1,0, 4);  // stall in FLUSH
      tv[33] = mk(0, 10'h000, 0,0,0,0, 8'h00, 10'h000,  10'h124,1,1,0, 5);

      idle_in();
      sbus.Start = 0; sbus.StartAddr = '0; sbus.Stall = 0; sbus.Halt = 0;
      sbus.Jump = 0; sbus.BranchRel = 0; sbus.Offset = '0; sbus.Target = '0;

      // Reset state
      Reset = 1;
      step();
      step();
      Reset = 0;
      chk_main("reset", 0, 0, 0, 0, 0);
      chk("reset.sat.CycleCount", int'(sbus.CycleCount), 0);

      // Stall in IDLE blocks Start
      bus.Start = 1; bus.StartAddr = 10'h155; bus.Stall = 1;
      step();
      chk_main("idle_stall", 0, 0, 0, 0, 0);
      idle_in();
      step();
      chk_main("idle_hold", 0, 0, 0, 0, 0);

      // Table-driven sequence
      for (int i = 0; i < 34; i++) begin
         bus.Start = tv[i].start; bus.StartAddr = tv[i].saddr; bus.Stall = tv[i].stall;
         bus.Halt = tv[i].halt; bus.Jump = tv[i].jump; bus.BranchRel = tv[i].rel;
         bus.Offset = tv[i].off; bus.Target = tv[i].tgt;
         step();
         chk_main($sformatf("vec%0d", i), int'(tv[i].pc), int'(tv[i].iv),
                  int'(tv[i].run), int'(tv[i].done), int'(tv[i].cnt));
      end

      // Reset during FLUSH aborts the pending branch
      idle_in();
      bus.Jump = 1; bus.Target = 10'h050;
      step();
      chk_main("pre_rst_flush", 10'h050, 0, 1, 0, 6);
      Reset = 1; bus.Jump = 1; bus.Target = 10'h300;
      step();
      Reset = 0;
      idle_in();
      chk_main("rst_in_flush", 0, 0, 0, 0, 0);
      step();
      chk_main("rst_after", 0, 0, 0, 0, 0);

      // CW=4 counter saturates at 15 over a 20-cycle run
      sbus.Start = 1; sbus.StartAddr = 10'h000;
      step();
      sbus.Start = 0;
      chk("sat.start_cnt", int'(sbus.CycleCount), 0);
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 14) chk("sat.cnt14", int'(sbus.CycleCount), 14);
      end
      chk("sat.cnt20", int'(sbus.CycleCount), 15);
      chk("sat.pc20",  int'(sbus.PC), 20);
      chk("sat.iv",    int'(sbus.InstValid), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
